line_buff_ctrl: RTL

Sequences the two ping-pong VGA line buffers (A = index 0, B = index 1) across a frame. It prefills both buffers before the first active line, selects which buffer drives the display on each line, and generates the tile read index. Each buffer is refilled with line n+2 as soon as line n has been displayed from it. The block sits between the VGA timing generator and the line buffer wrapper, and flags display underruns.

---
 rtl/line_buff_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/line_buff_ctrl.sv
// Ping-pong line buffer sequencer: prefills buffers A/B, selects the displayed
// buffer each line, generates the tile read index and flags display underruns.
module line_buff_ctrl #(
    parameter int WIDTH_PX       = 640,
    parameter int HEIGHT_PX      = 480,
    parameter int TILE_WIDTH     = 4,
    parameter int TILE_PER_LINE  = WIDTH_PX / TILE_WIDTH,
    parameter int TILE_CTR_WIDTH = $clog2(TILE_PER_LINE),
    parameter int LINE_CTR_WIDTH = $clog2(HEIGHT_PX)
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      frame_start_i,
    input  logic                      line_start_i,
    input  logic                      pxl_en_i,
    input  logic [1:0]                buff_fill_done_i,
    output logic [1:0]                buff_fill_req_o,
    output logic [LINE_CTR_WIDTH-1:0] fill_line_a_o,
    output logic [LINE_CTR_WIDTH-1:0] fill_line_b_o,
    output logic [1:0]                buff_sel_o,
    output logic [TILE_CTR_WIDTH-1:0] disp_pxl_id_o,
    output logic                      underrun_o
);

    localparam int SUB_W = (TILE_WIDTH > 1) ? $clog2(TILE_WIDTH) : 1;
    localparam logic [SUB_W-1:0]          SUB_LAST  = SUB_W'(TILE_WIDTH - 1);
    localparam logic [TILE_CTR_WIDTH-1:0] TILE_LAST = TILE_CTR_WIDTH'(TILE_PER_LINE - 1);
    localparam logic [LINE_CTR_WIDTH-1:0] LINE_LAST = LINE_CTR_WIDTH'(HEIGHT_PX - 1);

    typedef enum logic [1:0] {IDLE, PREFILL, WAIT_LINE, DISPLAY} state_t;

    state_t                    state_q;
    logic [1:0]                req_q;
    logic [LINE_CTR_WIDTH-1:0] fill_line_a_q;
    logic [LINE_CTR_WIDTH-1:0] fill_line_b_q;
    logic [1:0]                sel_q;
    logic [TILE_CTR_WIDTH-1:0] pxl_id_q;
    logic                      underrun_q;
    logic                      disp_idx_q;
    logic [LINE_CTR_WIDTH-1:0] disp_line_q;
    logic [SUB_W-1:0]          sub_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= IDLE;
            req_q         <= 2'b00;
            fill_line_a_q <= '0;
            fill_line_b_q <= '0;
            sel_q         <= 2'b00;
            pxl_id_q      <= '0;
            underrun_q    <= 1'b0;
            disp_idx_q    <= 1'b0;
            disp_line_q   <= '0;
            sub_q         <= '0;
        end else begin
            // Fill completions are applied first so a same-edge new request wins.
            if (state_q != IDLE) begin
                req_q <= req_q & ~buff_fill_done_i;
            end

            case (state_q)
                IDLE: begin
                    if (frame_start_i) begin
                        req_q         <= 2'b01;
                        fill_line_a_q <= '0;
                        disp_idx_q    <= 1'b0;
                        disp_line_q   <= '0;
                        state_q       <= PREFILL;
                    end
                end

                PREFILL: begin
                    if (line_start_i) begin
                        underrun_q <= 1'b1;
                    end
                    if (buff_fill_done_i[0]) begin
                        if (HEIGHT_PX > 1) begin
                            req_q[1]      <= 1'b1;
                            fill_line_b_q <= LINE_CTR_WIDTH'(1);
                        end
                        state_q <= WAIT_LINE;
                    end
                end

                WAIT_LINE: begin
                    if (line_start_i) begin
                        sel_q    <= disp_idx_q ? 2'b10 : 2'b01;
                        pxl_id_q <= '0;
                        sub_q    <= '0;
                        if (req_q[disp_idx_q]) begin
                            underrun_q <= 1'b1;
                        end
                        state_q <= DISPLAY;
                    end
                end

                DISPLAY: begin
                    if (pxl_en_i) begin
                        if (sub_q == SUB_LAST) begin
                            sub_q <= '0;
                            if (pxl_id_q == TILE_LAST) begin
                                sel_q    <= 2'b00;
                                pxl_id_q <= '0;
                                if (req_q[disp_idx_q]) begin
                                    underrun_q <= 1'b1;
                                end
                                // The buffer just shown is reloaded with the line two ahead.
                                if (int'(disp_line_q) + 2 < HEIGHT_PX) begin
                                    req_q[disp_idx_q] <= 1'b1;
                                    if (disp_idx_q) begin
                                        fill_line_b_q <= disp_line_q + LINE_CTR_WIDTH'(2);
                                    end else begin
                                        fill_line_a_q <= disp_line_q + LINE_CTR_WIDTH'(2);
                                    end
                                end
                                disp_idx_q  <= ~disp_idx_q;
                                disp_line_q <= disp_line_q + LINE_CTR_WIDTH'(1);
                                state_q     <= (disp_line_q == LINE_LAST) ? IDLE : WAIT_LINE;
                            end else begin
                                pxl_id_q <= pxl_id_q + TILE_CTR_WIDTH'(1);
                            end
                        end else begin
                            sub_q <= sub_q + SUB_W'(1);
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign buff_fill_req_o = req_q;
    assign fill_line_a_o   = fill_line_a_q;
    assign fill_line_b_o   = fill_line_b_q;
    assign buff_sel_o      = sel_q;
    assign disp_pxl_id_o   = pxl_id_q;
    assign underrun_o      = underrun_q;

endmodule
